// File: rtl/block_mult_8x8_engine_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | block_mult_8x8_engine_if : block-multiply handshake plus memory read port |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface block_mult_8x8_engine_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DIM_WIDTH  = 16
);
  logic                             mult_start;
  logic [ADDR_WIDTH-1:0]            base_A;
  logic [ADDR_WIDTH-1:0]            base_B;
  logic [DIM_WIDTH-1:0]             dim_col_A;
  logic [DIM_WIDTH-1:0]             dim_col_B;
  logic                             mult_done;
  logic [7:0][7:0][DATA_WIDTH-1:0]  mult_out;
  logic                             busy;
  logic                             rd_req;
  logic [ADDR_WIDTH-1:0]            rd_addr;
  logic                             rd_ready;
  logic                             rd_valid;
  logic [7:0][DATA_WIDTH-1:0]       rd_data;

  modport slave (
    input  mult_start, base_A, base_B, dim_col_A, dim_col_B,
    input  rd_ready, rd_valid, rd_data,
    output mult_done, mult_out, busy, rd_req, rd_addr
  );

  modport master (
    output mult_start, base_A, base_B, dim_col_A, dim_col_B,
    output rd_ready, rd_valid, rd_data,
    input  mult_done, mult_out, busy, rd_req, rd_addr
  );
endinterface
`default_nettype wire

// File: rtl/block_mult_8x8_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | block_mult_8x8_engine : fetches 8x8 blocks A and B, returns C = A*B       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module block_mult_8x8_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DIM_WIDTH  = 16
) (
  input  wire logic             clock,
  input  wire logic             reset,
  block_mult_8x8_engine_if.slave bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_COMPUTE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  typedef logic [7:0][7:0][DATA_WIDTH-1:0] block_t;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] base_b_q, base_b_d;
  logic [ADDR_WIDTH-1:0] stride_a_q, stride_a_d;
  logic [ADDR_WIDTH-1:0] stride_b_q, stride_b_d;
  logic [4:0]            req_cnt_q, req_cnt_d;
  logic [4:0]            resp_cnt_q, resp_cnt_d;
  logic [2:0]            k_q, k_d;
  block_t                a_q, a_d;
  block_t                b_q, b_d;
  block_t                acc_q, acc_d;
  block_t                mult_out_q, mult_out_d;

  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  busy;
  logic                  mult_done;
  logic                  start;
  logic                  req_fire;
  logic                  resp_fire;
  wire  [7:0][7:0][DATA_WIDTH-1:0] acc_sum;

  assign start     = (state_q == S_IDLE) && bus.mult_start;
  assign req_fire  = rd_req && bus.rd_ready;
  assign resp_fire = (state_q == S_FETCH) && bus.rd_valid && !resp_cnt_q[4];

  // One k-step of all 64 dot products; wraps to DATA_WIDTH bits.
  for (genvar gi = 0; gi < 8; gi++) begin : g_row
    for (genvar gj = 0; gj < 8; gj++) begin : g_col
      assign acc_sum[gi][gj] = acc_q[gi][gj] + a_q[gi][k_q] * b_q[k_q][gj];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.mult_start) state_d = S_FETCH;
      S_FETCH:   if (resp_fire && (resp_cnt_q == 5'd15)) state_d = S_COMPUTE;
      S_COMPUTE: if (k_q == 3'd7) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    mult_done = (state_q == S_DONE);
    rd_req    = (state_q == S_FETCH) && !req_cnt_q[4];
    rd_addr   = rd_req ? addr_q : '0;
  end

  assign bus.busy      = busy;
  assign bus.mult_done = mult_done;
  assign bus.rd_req    = rd_req;
  assign bus.rd_addr   = rd_addr;
  assign bus.mult_out  = mult_out_q;

  always_comb begin
    addr_d     = addr_q;
    base_b_d   = base_b_q;
    stride_a_d = stride_a_q;
    stride_b_d = stride_b_q;
    req_cnt_d  = req_cnt_q;
    resp_cnt_d = resp_cnt_q;
    k_d        = k_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    mult_out_d = mult_out_q;

    if (start) begin
      addr_d     = bus.base_A;
      base_b_d   = bus.base_B;
      stride_a_d = ADDR_WIDTH'(bus.dim_col_A);
      stride_b_d = ADDR_WIDTH'(bus.dim_col_B);
      req_cnt_d  = '0;
      resp_cnt_d = '0;
      k_d        = '0;
      acc_d      = '0;
    end

    // The running address walks A rows, then jumps to base_B for the B rows.
    if (req_fire) begin
      req_cnt_d = req_cnt_q + 5'd1;
      if (req_cnt_q == 5'd7) begin
        addr_d = base_b_q;
      end else if (!req_cnt_q[3]) begin
        addr_d = addr_q + stride_a_q;
      end else begin
        addr_d = addr_q + stride_b_q;
      end
    end

    if (resp_fire) begin
      resp_cnt_d = resp_cnt_q + 5'd1;
      if (!resp_cnt_q[3]) begin
        a_d[resp_cnt_q[2:0]] = bus.rd_data;
      end else begin
        b_d[resp_cnt_q[2:0]] = bus.rd_data;
      end
    end

    // The final sum is captured on the last step so it is visible during DONE.
    if (state_q == S_COMPUTE) begin
      k_d   = k_q + 3'd1;
      acc_d = acc_sum;
      if (k_q == 3'd7) begin
        mult_out_d = acc_sum;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      base_b_q   <= '0;
      stride_a_q <= '0;
      stride_b_q <= '0;
      req_cnt_q  <= '0;
      resp_cnt_q <= '0;
      k_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      mult_out_q <= '0;
    end else begin
      addr_q     <= addr_d;
      base_b_q   <= base_b_d;
      stride_a_q <= stride_a_d;
      stride_b_q <= stride_b_d;
      req_cnt_q  <= req_cnt_d;
      resp_cnt_q <= resp_cnt_d;
      k_q        <= k_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      mult_out_q <= mult_out_d;
    end
  end

endmodule
`default_nettype wire
